// File: rtl/ext_unit.sv
// ext_unit: widens a WIDTH_IN-bit field to WIDTH_OUT bits with sign or zero fill.
// dout is always combinational. Define EXT_UNIT_REG_OUT_EN to build a one-cycle
// registered copy (dout_q/out_valid). Without the macro, dout_q/out_valid are
// combinational pass-throughs and clk/rst are unused.
module ext_unit #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ExtOp,
    input  logic [WIDTH_IN-1:0]  din,
    input  logic                 in_valid,
    output logic [WIDTH_OUT-1:0] dout,
    output logic [WIDTH_OUT-1:0] dout_q,
    output logic                 out_valid
);

    localparam int PAD = WIDTH_OUT - WIDTH_IN;

    // Reject impossible geometries at elaboration time.
    if (WIDTH_IN < 1 || WIDTH_OUT < WIDTH_IN) begin : g_param_check
        $error("ext_unit: illegal parameters WIDTH_IN=%0d WIDTH_OUT=%0d", WIDTH_IN, WIDTH_OUT);
    end

    // Fill bit for the upper field: the input's MSB when sign-extending, else 0.
    logic fill;
    assign fill = ExtOp & din[WIDTH_IN-1];

    // Combinational extension; equal widths are a plain pass-through.
    if (PAD == 0) begin : g_no_pad
        assign dout = din;
    end else begin : g_pad
        assign dout = {{PAD{fill}}, din};
    end

`ifdef EXT_UNIT_REG_OUT_EN
    logic [WIDTH_OUT-1:0] data_d, data_q;
    logic                 valid_d, valid_q;

    // Next-state: capture on in_valid, otherwise hold the data and drop valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        data_d  = data_q;
        valid_d = 1'b0;
        if (in_valid) begin
            data_d  = dout;
            valid_d = 1'b1;
        end
    end

    // Pipeline register with synchronous reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout_q    = data_q;
    assign out_valid = valid_q;
`else
    // No registered stage: outputs follow the inputs in the same cycle.
    assign dout_q    = dout;
    assign out_valid = in_valid;

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_ext_unit.sv
// Self-checking bench for ext_unit: directed vectors for 8->32, 16->32 and 32->32,
// then randomized traffic compared against an arithmetic reference model.
// Works for both builds (EXT_UNIT_REG_OUT_EN defined or not).
module tb_ext_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;

    logic        ext8;
    logic [7:0]  din8;
    logic [31:0] dout8, doutq8;
    logic        ov8;

    logic        ext16;
    logic [15:0] din16;
    logic [31:0] dout16, doutq16;
    logic        ov16;

    logic        ext32;
    logic [31:0] din32;
    logic [31:0] dout32, doutq32;
    logic        ov32;

    int n_checks = 0;
    int n_errors = 0;

    // Expected registered state of the 8->32 instance.
    logic [63:0] m_q;
    logic        m_v;

    always #5 clk = ~clk;

    ext_unit #(.WIDTH_IN(8), .WIDTH_OUT(32)) u8 (
        .clk(clk), .rst(rst), .ExtOp(ext8), .din(din8), .in_valid(in_valid),
        .dout(dout8), .dout_q(doutq8), .out_valid(ov8)
    );

    ext_unit #(.WIDTH_IN(16), .WIDTH_OUT(32)) u16 (
        .clk(clk), .rst(rst), .ExtOp(ext16), .din(din16), .in_valid(in_valid),
        .dout(dout16), .dout_q(doutq16), .out_valid(ov16)
    );

    ext_unit #(.WIDTH_IN(32), .WIDTH_OUT(32)) u32 (
        .clk(clk), .rst(rst), .ExtOp(ext32), .din(din32), .in_valid(in_valid),
        .dout(dout32), .dout_q(doutq32), .out_valid(ov32)
    );

    // Reference: treat din as an unsigned number; when sign-extending a negative
    // value, its true value is din - 2^win, taken modulo 2^wout.
    function automatic logic [63:0] ref_ext(int win, int wout, logic [63:0] d, logic e);
        logic [63:0] v;
        v = d & ((64'd1 << win) - 64'd1);
        if (e && (wout > win) && (v >= (64'd1 << (win - 1))))
            v = v + (64'd1 << wout) - (64'd1 << win);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge; the model advances from the inputs seen just before it.
    task automatic tick();
        if (rst) begin
            m_q = 64'd0;
            m_v = 1'b0;
        end else if (in_valid) begin
            m_q = ref_ext(8, 32, {56'd0, din8}, ext8);
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag);
        check({tag, "_dout8"},  {32'd0, dout8},  ref_ext(8, 32, {56'd0, din8}, ext8));
        check({tag, "_dout16"}, {32'd0, dout16}, ref_ext(16, 32, {48'd0, din16}, ext16));
        check({tag, "_dout32"}, {32'd0, dout32}, ref_ext(32, 32, {32'd0, din32}, ext32));
    endtask

    task automatic check_reg(input string tag);
`ifdef EXT_UNIT_REG_OUT_EN
        check({tag, "_dout_q"},    {32'd0, doutq8}, m_q);
        check({tag, "_out_valid"}, {63'd0, ov8},    {63'd0, m_v});
`else
        check({tag, "_dout_q"},    {32'd0, doutq8}, ref_ext(8, 32, {56'd0, din8}, ext8));
        check({tag, "_out_valid"}, {63'd0, ov8},    {63'd0, in_valid});
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        ext8 = 1'b0; din8 = '0; ext16 = 1'b0; din16 = '0; ext32 = 1'b0; din32 = '0;
        m_q = 64'd0; m_v = 1'b0;

        // Reset for two edges.
        tick();
        tick();
        check_reg("reset");
`ifdef EXT_UNIT_REG_OUT_EN
        check("reset_dout_q_zero", {32'd0, doutq8}, 64'd0);
`endif

        // Directed combinational vectors with hand-derived results.
        ext8 = 1'b1; din8 = 8'h80; #1; check("s8_80", {32'd0, dout8}, 64'hFFFF_FF80);
        ext8 = 1'b0; din8 = 8'h80; #1; check("z8_80", {32'd0, dout8}, 64'h0000_0080);
        ext8 = 1'b1; din8 = 8'h7F; #1; check("s8_7f", {32'd0, dout8}, 64'h0000_007F);
        ext8 = 1'b1; din8 = 8'hFF; #1; check("s8_ff", {32'd0, dout8}, 64'hFFFF_FFFF);
        ext8 = 1'b0; din8 = 8'hFF; #1; check("z8_ff", {32'd0, dout8}, 64'h0000_00FF);
        ext16 = 1'b1; din16 = 16'h8000; #1; check("s16_8000", {32'd0, dout16}, 64'hFFFF_8000);
        ext16 = 1'b0; din16 = 16'h8000; #1; check("z16_8000", {32'd0, dout16}, 64'h0000_8000);
        ext32 = 1'b1; din32 = 32'h8000_0001; #1; check("s32_pass", {32'd0, dout32}, 64'h8000_0001);
        ext32 = 1'b0; din32 = 32'h8000_0001; #1; check("z32_pass", {32'd0, dout32}, 64'h8000_0001);

`ifndef EXT_UNIT_REG_OUT_EN
        // Pass-through build: outputs follow inputs with no clock edge.
        in_valid = 1'b1; ext8 = 1'b1; din8 = 8'h90; #1;
        check("comb_dout_q", {32'd0, doutq8}, 64'hFFFF_FF90);
        check("comb_out_valid", {63'd0, ov8}, 64'd1);
        in_valid = 1'b0; #1;
`endif

        // Back-to-back valid samples, then an idle cycle.
        rst = 1'b0;
        in_valid = 1'b1; ext8 = 1'b1; din8 = 8'h80;
        tick();
`ifdef EXT_UNIT_REG_OUT_EN
        check("b2b0_const", {32'd0, doutq8}, 64'hFFFF_FF80);
`endif
        check_reg("b2b0");
        ext8 = 1'b0; din8 = 8'h01;
        tick();
`ifdef EXT_UNIT_REG_OUT_EN
        check("b2b1_const", {32'd0, doutq8}, 64'h0000_0001);
`endif
        check_reg("b2b1");
        in_valid = 1'b0; ext8 = 1'b1; din8 = 8'hC3;
        tick();
        check_reg("idle_hold");
`ifdef EXT_UNIT_REG_OUT_EN
        check("idle_hold_const", {32'd0, doutq8}, 64'h0000_0001);
`endif

        // Reset wins over in_valid; dout keeps extending.
        in_valid = 1'b1; ext8 = 1'b1; din8 = 8'hA5;
        tick();
        in_valid = 1'b1; rst = 1'b1; ext8 = 1'b1; din8 = 8'h9C;
        tick();
        check_comb("rstprio");
        check("rstprio_dout_const", {32'd0, dout8}, 64'hFFFF_FF9C);
`ifdef EXT_UNIT_REG_OUT_EN
        check("rstprio_out_valid", {63'd0, ov8}, 64'd0);
        check("rstprio_dout_q", {32'd0, doutq8}, 64'd0);
`else
        check_reg("rstprio");
`endif
        // First non-reset edge captures normally.
        rst = 1'b0; ext8 = 1'b0; din8 = 8'hF0;
        tick();
        check_reg("rst_release");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            ext8  = 1'($urandom);  din8  = 8'($urandom);
            ext16 = 1'($urandom);  din16 = 16'($urandom);
            ext32 = 1'($urandom);  din32 = $urandom;
            in_valid = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 15) == 0);
            #1;
            check_comb("rand");
            tick();
            check_reg("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ext_unit.md
# ext_unit

Parameterized sign/zero extender for the datapath. It widens a WIDTH_IN-bit field to WIDTH_OUT bits, and ExtOp selects sign or zero fill. Uses: byte/halfword load data from the data memory (8→32) and instruction immediates (16→32). It provides a zero-latency combinational result and an optional one-cycle registered copy with a valid flag.

## Interface
Parameters:
- WIDTH_IN, default 8: width of input field; must be ≥ 1.
- WIDTH_OUT, default 32: width of extended result; must be ≥ WIDTH_IN.

Ports:
- clk  input  1  clock; rising-edge.
- rst  input  1  reset, synchronous and active-high.
- ExtOp  input  1  1 = sign-extend, 0 = zero-extend.
- din  input  WIDTH_IN  field to extend.
- in_valid  input  1  qualifies din/ExtOp for the registered stage.
- dout  output  WIDTH_OUT  combinational extended result.
- dout_q  output  WIDTH_OUT  registered extended result.
- out_valid  output  1  dout_q holds a valid result.

## Operation
- dout[WIDTH_IN-1:0] = din.
- Upper bits dout[WIDTH_OUT-1:WIDTH_IN] depend on ExtOp:
  - ExtOp=1: every upper bit = din[WIDTH_IN-1].
  - ExtOp=0: every upper bit = 0.
- WIDTH_OUT == WIDTH_IN: dout = din, and ExtOp is ignored.
- dout depends only on din and ExtOp. It is independent of clk, rst and in_valid.
- Registered stage, when compiled in:
  - On each rising clk with in_valid=1: dout_q ← dout and out_valid ← 1.
  - On each rising clk with in_valid=0: out_valid ← 0 and dout_q holds its last value.
- X/undefined ExtOp is not a supported input. Behaviour is unspecified.
- Illegal parameters (WIDTH_OUT < WIDTH_IN, or WIDTH_IN < 1) must fail elaboration.

## Timing
- dout: zero-cycle latency, purely combinational.
- dout_q/out_valid: one-cycle latency.
  - A sample presented with in_valid=1 before rising edge N appears on dout_q, with out_valid=1, after edge N.
- There is no backpressure. Every valid input produces exactly one valid output cycle.
- Back-to-back valid inputs give back-to-back outputs at full throughput.
- Reset values, applied at a rising edge with rst=1: dout_q = 0, out_valid = 0.
  - rst has priority over in_valid on the same edge.
- Reset mid-stream: an in-flight sample is discarded, and out_valid is 0 on the cycle after the reset edge.
- Releasing rst with in_valid=1 on the first non-reset edge captures that sample normally.
- dout is unaffected by rst.

## Configuration
- Macro EXT_UNIT_REG_OUT_EN.
- Defined: the registered stage is built exactly as described above.
- Not defined:
  - No flops.
  - dout_q = dout and out_valid = in_valid, both combinational.
  - clk and rst are unused but remain as ports.
- dout behaves identically in both builds.

## Test plan
- Defaults (8→32), combinational: ExtOp=1, din=8'h80 → dout=32'hFFFF_FF80. ExtOp=0, din=8'h80 → dout=32'h0000_0080.
- Positive/edge values: ExtOp=1, din=8'h7F → 32'h0000_007F. ExtOp=1, din=8'hFF → 32'hFFFF_FFFF. ExtOp=0, din=8'hFF → 32'h0000_00FF.
- Parameters (16,32): ExtOp=1, din=16'h8000 → 32'hFFFF_8000. ExtOp=0, din=16'h8000 → 32'h0000_8000. Parameters (32,32): any ExtOp, din=32'h8000_0001 → dout=32'h8000_0001.
- Registered stage (macro defined): rst=1 for 2 edges → dout_q=0, out_valid=0. Then in_valid=1 with din=8'h80, ExtOp=1, then 8'h01, ExtOp=0, on consecutive edges → dout_q=32'hFFFF_FF80 then 32'h0000_0001, with out_valid=1 both cycles. Then in_valid=0 → out_valid=0 and dout_q holds 32'h0000_0001.
- Reset priority: in_valid=1 and rst=1 on the same edge → out_valid=0, dout_q=0. Meanwhile dout still shows the combinational extension.
- Macro undefined: in_valid=1, din=8'h90, ExtOp=1 → dout_q=32'hFFFF_FF90 and out_valid=1 in the same cycle, with no clock edge required.
